seq_mul: RTL and testbench

Parametrised sequential shift-and-add multiplier, successor to the combinational 2x2 array multiplier. Multiplies two WIDTH-bit operands over WIDTH clock cycles. Uses one WIDTH+1-bit adder instead of a full partial-product array. Sits as a shared arithmetic unit behind a start/done handshake, so larger widths do not cost an array's area.

---
 rtl/seq_mul_pkg.sv | 20 ++
 rtl/seq_mul_rca.sv | 21 ++
 rtl/seq_mul.sv | 112 +++++++++++
 tb/tb_seq_mul.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul shift-and-add multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..v-1 (at least 1).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_mul_rca.sv
// N-bit ripple-carry adder built from full adders; carry out of the top bit is dropped.
module rca #(
   parameter int unsigned N = 9
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic [N-1:0] s
);

   logic [N-1:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < N; i++) begin : g_fa
      assign s[i] = x[i] ^ y[i] ^ c[i];
      if (i + 1 < N) begin : g_carry
         assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-and-add multiplier with start/done handshake, WIDTH cycles per product.
// Define SEQ_MUL_SIGNED_EN for two's complement operands and product.
module seq_mul
   import seq_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int unsigned CW = clog2(WIDTH);
   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned PW = 2 * WIDTH;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [AW-1:0]    acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [CW-1:0]    cnt;

   logic [AW-1:0]    addend_c;
   logic [AW-1:0]    sum_c;
   logic [PW-1:0]    prod_c;
   logic [WIDTH-1:0] a_mag_c;
   logic [WIDTH-1:0] b_mag_c;
   logic [PW-1:0]    p_load_c;

   assign addend_c = acc_lo[0] ? {1'b0, mcand} : '0;

   rca #(.N(AW)) u_rca (
      .x (acc_hi),
      .y (addend_c),
      .s (sum_c)
   );

   // Product after the final add-and-shift; equals {acc_hi[WIDTH-1:0], acc_lo} post-shift.
   assign prod_c = {sum_c, acc_lo[WIDTH-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
   logic neg;

   assign a_mag_c  = a[WIDTH-1] ? WIDTH'(-a) : a;
   assign b_mag_c  = b[WIDTH-1] ? WIDTH'(-b) : b;
   assign p_load_c = neg ? PW'(-prod_c) : prod_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg <= 1'b0;
      end else if (state == IDLE && start) begin
         neg <= a[WIDTH-1] ^ b[WIDTH-1];
      end
   end
`else
   assign a_mag_c  = a;
   assign b_mag_c  = b;
   assign p_load_c = prod_c;
`endif

   // Control FSM, step counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         p      <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= a_mag_c;
                  acc_hi <= '0;
                  acc_lo <= b_mag_c;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc_hi <= {1'b0, sum_c[AW-1:1]};
               acc_lo <= {sum_c[0], acc_lo[WIDTH-1:1]};
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  p     <= p_load_c;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul at WIDTH=2 and WIDTH=8.
module tb_seq_mul;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start2;
   logic [1:0]  a2, b2;
   logic        busy2, done2;
   logic [3:0]  p2;

   logic        start8;
   logic [7:0]  a8, b8;
   logic        busy8, done8;
   logic [15:0] p8;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      string       name;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   seq_mul #(.WIDTH(2)) u_w2 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .busy  (busy2),
      .done  (done2),
      .p     (p2)
   );

   seq_mul #(.WIDTH(8)) u_w8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .busy  (busy8),
      .done  (done8),
      .p     (p8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One WIDTH=2 product; operands scrambled after capture.
   task automatic mul2(input logic [1:0] ta, input logic [1:0] tb);
      int lat;
      int ea, eb;
      logic [3:0] exp;
`ifdef SEQ_MUL_SIGNED_EN
      ea = int'($signed(ta));
      eb = int'($signed(tb));
`else
      ea = int'(ta);
      eb = int'(tb);
`endif
      exp = 4'(ea * eb);
      @(negedge clk);
      a2 = ta; b2 = tb; start2 = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         start2 = 1'b0;
         a2 = 2'($urandom);
         b2 = 2'($urandom);
         lat++;
      end while (!done2 && lat < 20);
      check($sformatf("w2 %0d*%0d p", ta, tb), 32'(p2), 32'(exp));
      check($sformatf("w2 %0d*%0d latency", ta, tb), 32'(lat), 32'd3);
      @(negedge clk);
      check($sformatf("w2 %0d*%0d idle", ta, tb), {30'd0, busy2, done2}, 32'd0);
   endtask

   // One WIDTH=8 product with latency, busy length and done-pulse width checks.
   task automatic mul8(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp,
                       input string nm);
      int lat, bcnt;
      @(negedge clk);
      a8 = ta; b8 = tb; start8 = 1'b1;
      lat = 0; bcnt = 0;
      do begin
         @(negedge clk);
         start8 = 1'b0;
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         lat++;
         if (busy8) bcnt++;
      end while (!done8 && lat < 40);
      check({nm, " p"}, 32'(p8), 32'(exp));
      check({nm, " latency"}, 32'(lat), 32'd9);
      check({nm, " busy_len"}, 32'(bcnt), 32'd9);
      @(negedge clk);
      check({nm, " idle"}, {30'd0, busy8, done8}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n  = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      #13;
      check("reset w8", {15'd0, busy8, done8, p8}, 32'd0);
      check("reset w2", {26'd0, busy2, done2, p2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            mul2(2'(i), 2'(j));
         end
      end

`ifdef SEQ_MUL_SIGNED_EN
      vecs.push_back('{8'h80, 8'h80, 16'h4000, "m128xm128"});
      vecs.push_back('{8'hFD, 8'h05, 16'hFFF1, "m3x5"});
      vecs.push_back('{8'h7F, 8'hFF, 16'hFF81, "127xm1"});
      vecs.push_back('{8'hFF, 8'hFF, 16'h0001, "m1xm1"});
      vecs.push_back('{8'h00, 8'h80, 16'h0000, "0xm128"});
`else
      vecs.push_back('{8'hFF, 8'hFF, 16'hFE01, "255x255"});
      vecs.push_back('{8'd0,  8'd200, 16'd0,   "0x200"});
      vecs.push_back('{8'd200, 8'd0,  16'd0,   "200x0"});
      vecs.push_back('{8'd128, 8'd2,  16'd256, "128x2"});
      vecs.push_back('{8'd13,  8'd11, 16'd143, "13x11"});
`endif
      vecs.push_back('{8'd9, 8'd9, 16'd81, "9x9"});
      foreach (vecs[k]) mul8(vecs[k].a, vecs[k].b, vecs[k].p, vecs[k].name);

      // p must hold 81 while operands wander and start stays low.
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("hold", {15'd0, done8, p8}, {15'd0, 1'b0, 16'd81});
         a8 = 8'($urandom);
         b8 = 8'($urandom);
      end

      // start held high: second product accepted only in the IDLE cycle after done.
      @(negedge clk);
      a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done8 && lat < 40);
      check("b2b first p", 32'(p8), 32'd63);
      check("b2b first latency", 32'(lat), 32'd9);
      a8 = 8'd12; b8 = 8'd12;
      @(negedge clk);
      check("b2b idle gap", {30'd0, busy8, done8}, 32'd0);
      check("b2b p stable", 32'(p8), 32'd63);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done8 && lat < 40);
      start8 = 1'b0;
      check("b2b second p", 32'(p8), 32'd144);
      check("b2b second latency", 32'(lat), 32'd9);
      @(negedge clk);
      @(negedge clk);

      // Asynchronous reset during RUN discards the partial result.
      a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset busy", 32'(busy8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrun reset w8", {15'd0, busy8, done8, p8}, 32'd0);
      check("midrun reset w2", {26'd0, busy2, done2, p2}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      mul8(8'd5, 8'd6, 16'd30, "post_reset 5x6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
